// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand muxing and
// load-use hazard detection.
module id_ex_stage #(
    parameter int       XLEN   = 32,
    parameter int       FWD_EN = 1,
    parameter logic [3:0] NOP_OP = 4'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic            id_reg_wr,
    input  logic            id_mem_rd,
    input  logic            id_mem_wr,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_wr,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_wr,
    input  logic [XLEN-1:0] wb_result,
    output logic            load_use_o,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_wr,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr
);

    localparam logic FwdOn = (FWD_EN != 0);

    logic            exValid_q,  exValid_d;
    logic [XLEN-1:0] exPc_q,     exPc_d;
    logic [XLEN-1:0] rs1Data_q,  rs1Data_d;
    logic [XLEN-1:0] rs2Data_q,  rs2Data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic [3:0]      aluOp_q,    aluOp_d;
    logic            src1Pc_q,   src1Pc_d;
    logic            src2Imm_q,  src2Imm_d;
    logic            regWr_q,    regWr_d;
    logic            memRd_q,    memRd_d;
    logic            memWr_q,    memWr_d;

    logic [XLEN-1:0] fwdRs1;
    logic [XLEN-1:0] fwdRs2;

    // Pick the freshest value for each latched source: MEM beats WB, x0 is never forwarded
    always_comb begin
        fwdRs1 = rs1Data_q;
        fwdRs2 = rs2Data_q;
        if (FwdOn) begin
            if (mem_reg_wr && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
                fwdRs1 = mem_result;
            end else if (wb_reg_wr && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
                fwdRs1 = wb_result;
            end
            if (mem_reg_wr && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
                fwdRs2 = mem_result;
            end else if (wb_reg_wr && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
                fwdRs2 = wb_result;
            end
        end
    end

    // A load in EX whose result the ID instruction needs forces a one-cycle bubble
    assign load_use_o = exValid_q && memRd_q && (rd_q != 5'd0) && id_valid &&
                        ((rd_q == id_rs1) ||
                         ((rd_q == id_rs2) && (!id_src2_imm || id_mem_wr)));

    // Next-state selection: flush beats stall beats load-use bubble beats a normal load
    always_comb begin
        exValid_d = exValid_q;
        exPc_d    = exPc_q;
        rs1Data_d = rs1Data_q;
        rs2Data_d = rs2Data_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        aluOp_d   = aluOp_q;
        src1Pc_d  = src1Pc_q;
        src2Imm_d = src2Imm_q;
        regWr_d   = regWr_q;
        memRd_d   = memRd_q;
        memWr_d   = memWr_q;
        if (flush_i || (!stall_i && load_use_o)) begin
            exValid_d = 1'b0;
            regWr_d   = 1'b0;
            memRd_d   = 1'b0;
            memWr_d   = 1'b0;
            aluOp_d   = NOP_OP;
        end else if (stall_i) begin
            rs1Data_d = fwdRs1;
            rs2Data_d = fwdRs2;
        end else begin
            exValid_d = id_valid;
            exPc_d    = id_pc;
            rs1Data_d = id_rs1_data;
            rs2Data_d = id_rs2_data;
            imm_d     = id_imm;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rd_d      = id_rd;
            aluOp_d   = id_alu_op;
            src1Pc_d  = id_src1_pc;
            src2Imm_d = id_src2_imm;
            regWr_d   = id_reg_wr && id_valid;
            memRd_d   = id_mem_rd && id_valid;
            memWr_d   = id_mem_wr && id_valid;
        end
    end

    // Pipeline register bank, cleared asynchronously to an empty NOP slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid_q <= 1'b0;
            exPc_q    <= '0;
            rs1Data_q <= '0;
            rs2Data_q <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            aluOp_q   <= NOP_OP;
            src1Pc_q  <= 1'b0;
            src2Imm_q <= 1'b0;
            regWr_q   <= 1'b0;
            memRd_q   <= 1'b0;
            memWr_q   <= 1'b0;
        end else begin
            exValid_q <= exValid_d;
            exPc_q    <= exPc_d;
            rs1Data_q <= rs1Data_d;
            rs2Data_q <= rs2Data_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            aluOp_q   <= aluOp_d;
            src1Pc_q  <= src1Pc_d;
            src2Imm_q <= src2Imm_d;
            regWr_q   <= regWr_d;
            memRd_q   <= memRd_d;
            memWr_q   <= memWr_d;
        end
    end

    assign ex_valid      = exValid_q;
    assign ex_pc         = exPc_q;
    assign alu_op        = aluOp_q;
    assign ex_rd         = rd_q;
    assign ex_reg_wr     = regWr_q;
    assign ex_mem_rd     = memRd_q;
    assign ex_mem_wr     = memWr_q;
    assign alu_in1       = src1Pc_q  ? exPc_q : fwdRs1;
    assign alu_in2       = src2Imm_q ? imm_q  : fwdRs2;
    assign ex_store_data = fwdRs2;

endmodule
